// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer so in_ready comes straight from a flop.
// Carries an opaque payload, supports a squash (flush) and counts downstream stall cycles.
//
//   state | meaning
//   EMPTY | no entry held (main_v=0, skid_v=0)
//   ONE   | head entry in main (main_v=1, skid_v=0)
//   FULL  | head in main, next entry parked in skid (main_v=1, skid_v=1)
module pipe_stage_skid #(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  // bit 0 is main_v, bit 1 is skid_v
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_v;
  logic             skid_v;
  logic             push;
  logic             pop;
  logic             load_main;
  logic             load_skid;

  assign main_v = state[0];
  assign skid_v = state[1];
  assign push   = in_valid & ~skid_v;
  assign pop    = main_v & out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (!push && pop) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  always_comb begin
    in_ready  = ~skid_v;
    out_valid = main_v;
    occupancy = {1'b0, main_v} + {1'b0, skid_v};
    out_data  = main_q;
  end

  // A push during flush is discarded, so the data registers stay untouched that cycle too.
  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY:   load_main = push;
        ONE: begin
          load_main = push & pop;
          load_skid = push & ~pop;
        end
        FULL:    load_main = pop;
        default: load_main = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_q <= RESET_DATA;
      skid_q <= RESET_DATA;
    end else begin
      if (load_main) main_q <= skid_v ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      stall_cycles <= '0;
    else if (main_v && !out_ready && !flush && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule
